elevator_scheduler: RTL

//  Single-car SCAN scheduler; sits between the button latch block and the car drive.

---
 rtl/elevator_pkg.sv | 33 +++
 rtl/elevator_req_eval.sv | 42 ++++
 rtl/elevator_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and defaults for the single-car SCAN elevator scheduler.
package elevator_pkg;

    typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_t;

    typedef struct packed {
        logic here;
        logic in_here;
        logic up_here;
        logic down_here;
        logic above;
        logic below;
        logic stop;
    } req_eval_t;

    localparam int DEF_BUTTONS_WIDTH = 8;
    localparam int DEF_FLOOR_TICKS   = 16;
    localparam int DEF_DOOR_TICKS    = 32;
    localparam int DEF_LEVEL_W       = $clog2(DEF_BUTTONS_WIDTH);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Keep the sweep while work lies ahead, else turn if work lies behind.
    function automatic logic decide_dir(input logic dir_up, input logic above, input logic below);
        if (dir_up)
            return above || !below;
        else
            return above && !below;
    endfunction

endpackage

// File: rtl/elevator_req_eval.sv
// Combinational request decode around one level: here/above/below and the SCAN stop test.
module elevator_req_eval
    import elevator_pkg::*;
#(
    parameter int BUTTONS_WIDTH = DEF_BUTTONS_WIDTH,
    parameter int LEVEL_W       = $clog2(BUTTONS_WIDTH)
) (
    input  logic [BUTTONS_WIDTH-1:0] in_levels,
    input  logic [BUTTONS_WIDTH-2:0] up_levels,
    input  logic [BUTTONS_WIDTH-1:1] down_levels,
    input  logic [LEVEL_W-1:0]       level,
    input  logic                     dir_up,
    output req_eval_t                res
);

    logic [BUTTONS_WIDTH-1:0] up_full;
    logic [BUTTONS_WIDTH-1:0] down_full;
    logic [BUTTONS_WIDTH-1:0] any_req;

    assign up_full   = {1'b0, up_levels};
    assign down_full = {down_levels, 1'b0};
    assign any_req   = in_levels | up_full | down_full;

    // An opposite-direction hall call only stops the car when nothing lies further ahead.
    always_comb begin
        res = '0;
        for (int i = 0; i < BUTTONS_WIDTH; i++) begin
            if (i > int'(level))
                res.above = res.above | any_req[i];
            if (i < int'(level))
                res.below = res.below | any_req[i];
        end
        res.here      = any_req[level];
        res.in_here   = in_levels[level];
        res.up_here   = up_full[level];
        res.down_here = down_full[level];
        res.stop      = res.in_here
                      | (dir_up ? res.up_here : res.down_here)
                      | ((dir_up ? res.down_here : res.up_here) & ~(dir_up ? res.above : res.below));
    end

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car SCAN scheduler: FSM, shared tick counter, level register and clear-pulse registers.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int BUTTONS_WIDTH = DEF_BUTTONS_WIDTH,
    parameter int FLOOR_TICKS   = DEF_FLOOR_TICKS,
    parameter int DOOR_TICKS    = DEF_DOOR_TICKS,
    parameter int LEVEL_W       = $clog2(BUTTONS_WIDTH)
) (
    input  logic                     clk,
    input  logic                     an_reset,
    input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
    input  logic [BUTTONS_WIDTH-2:0] active_out_up_levels,
    input  logic [BUTTONS_WIDTH-1:1] active_out_down_levels,
    input  logic                     door_obstruct,
    output logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
    output logic [BUTTONS_WIDTH-2:0] inactivate_out_up_levels,
    output logic [BUTTONS_WIDTH-1:1] inactivate_out_down_levels,
    output logic [LEVEL_W-1:0]       current_level,
    output logic                     motor_up,
    output logic                     motor_down,
    output logic                     door_open,
    output logic                     dir_up
);

    localparam int                 CNT_W      = $clog2(max_int(FLOOR_TICKS, DOOR_TICKS) + 1);
    localparam logic [LEVEL_W-1:0] TOP_LEVEL  = LEVEL_W'(BUTTONS_WIDTH - 1);
    localparam logic [CNT_W-1:0]   FLOOR_LAST = CNT_W'(FLOOR_TICKS - 1);
    localparam logic [CNT_W-1:0]   DOOR_LAST  = CNT_W'(DOOR_TICKS - 1);

    state_t                   state;
    logic [CNT_W-1:0]         counter;
    logic [LEVEL_W-1:0]       nxt_level;
    logic [LEVEL_W-1:0]       ent_level;
    req_eval_t                cur_eval;
    req_eval_t                nxt_eval;
    req_eval_t                ent;
    logic                     ent_dir;
    logic                     ent_none;
    logic                     idle_up;
    logic                     ahead;
    logic                     pulse_active;
    logic                     reserve;
    logic [BUTTONS_WIDTH-1:0] clr_in;
    logic [BUTTONS_WIDTH-2:0] clr_up;
    logic [BUTTONS_WIDTH-1:1] clr_down;

    always_comb begin
        nxt_level = current_level;
        if (dir_up && current_level != TOP_LEVEL)
            nxt_level = current_level + LEVEL_W'(1);
        else if (!dir_up && current_level != '0)
            nxt_level = current_level - LEVEL_W'(1);
    end

    elevator_req_eval #(.BUTTONS_WIDTH(BUTTONS_WIDTH), .LEVEL_W(LEVEL_W)) u_cur_eval (
        .in_levels   (active_in_levels),
        .up_levels   (active_out_up_levels),
        .down_levels (active_out_down_levels),
        .level       (current_level),
        .dir_up      (dir_up),
        .res         (cur_eval)
    );

    elevator_req_eval #(.BUTTONS_WIDTH(BUTTONS_WIDTH), .LEVEL_W(LEVEL_W)) u_nxt_eval (
        .in_levels   (active_in_levels),
        .up_levels   (active_out_up_levels),
        .down_levels (active_out_down_levels),
        .level       (nxt_level),
        .dir_up      (dir_up),
        .res         (nxt_eval)
    );

    // While moving, decisions concern the level being arrived at; otherwise the current one.
    // IDLE uses the stop test rather than bare "here" so an opposite hall call at L with work
    // ahead is left for the return sweep instead of reopening the door forever.
    always_comb begin
        ent       = (state == MOVING) ? nxt_eval : cur_eval;
        ent_level = (state == MOVING) ? nxt_level : current_level;
        ent_dir   = decide_dir(dir_up, ent.above, ent.below);
        ent_none  = ~ent.above & ~ent.below;
        idle_up   = (ent.above & ent.below) ? dir_up : ent.above;
        ahead     = dir_up ? ent.above : ent.below;
        pulse_active = (|inactivate_in_levels) | (|inactivate_out_up_levels)
                     | (|inactivate_out_down_levels);
        reserve   = ~pulse_active & (ent.in_here | (ent_dir ? ent.up_here : ent.down_here)
                                     | (ent_none & ent.here));
        clr_in    = '0;
        clr_up    = '0;
        clr_down  = '0;
        for (int i = 0; i < BUTTONS_WIDTH; i++) begin
            if (i == int'(ent_level)) begin
                clr_in[i] = 1'b1;
                if (i < BUTTONS_WIDTH - 1 && (ent_dir || ent_none))
                    clr_up[i] = 1'b1;
                if (i > 0 && (!ent_dir || ent_none))
                    clr_down[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge an_reset) begin
        if (!an_reset) begin
            state                      <= IDLE;
            counter                    <= '0;
            current_level              <= '0;
            dir_up                     <= 1'b1;
            motor_up                   <= 1'b0;
            motor_down                 <= 1'b0;
            door_open                  <= 1'b0;
            inactivate_in_levels       <= '0;
            inactivate_out_up_levels   <= '0;
            inactivate_out_down_levels <= '0;
        end else begin
            inactivate_in_levels       <= '0;
            inactivate_out_up_levels   <= '0;
            inactivate_out_down_levels <= '0;
            case (state)
                IDLE: begin
                    counter <= '0;
                    if (ent.stop) begin
                        state                      <= DOOR_OPEN;
                        door_open                  <= 1'b1;
                        dir_up                     <= ent_dir;
                        inactivate_in_levels       <= clr_in;
                        inactivate_out_up_levels   <= clr_up;
                        inactivate_out_down_levels <= clr_down;
                    end else if (ent.above || ent.below) begin
                        state      <= MOVING;
                        dir_up     <= idle_up;
                        motor_up   <= idle_up;
                        motor_down <= ~idle_up;
                    end
                end
                MOVING: begin
                    if (counter >= FLOOR_LAST) begin
                        counter       <= '0;
                        current_level <= nxt_level;
                        if (ent.stop) begin
                            state                      <= DOOR_OPEN;
                            motor_up                   <= 1'b0;
                            motor_down                 <= 1'b0;
                            door_open                  <= 1'b1;
                            dir_up                     <= ent_dir;
                            inactivate_in_levels       <= clr_in;
                            inactivate_out_up_levels   <= clr_up;
                            inactivate_out_down_levels <= clr_down;
                        end else if (!ahead) begin
                            state      <= IDLE;
                            motor_up   <= 1'b0;
                            motor_down <= 1'b0;
                        end
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                DOOR_OPEN: begin
                    if (door_obstruct || reserve) begin
                        counter                    <= '0;
                        dir_up                     <= ent_dir;
                        inactivate_in_levels       <= clr_in;
                        inactivate_out_up_levels   <= clr_up;
                        inactivate_out_down_levels <= clr_down;
                    end else if (counter >= DOOR_LAST) begin
                        state     <= IDLE;
                        counter   <= '0;
                        door_open <= 1'b0;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
